memory_arbiter_2port: RTL and testbench

Two-requester front end for the memory interface: it merges the instruction-fetch port and the data load/store port into the single CPU request bus of `memory_if`. Arbitration is round-robin. The granted request is registered toward memory. Every accepted read is tagged with its requester in an in-order tag FIFO, so the 64-bit read responses returned by `memory_if` (strictly in request order) are steered back to the correct port.

---
 rtl/memory_arbiter_pkg.sv | 24 ++
 rtl/memory_arbiter_tag_fifo.sv | 66 ++++++
 rtl/memory_arbiter_2port.sv | 161 ++++++++++++++++
 tb/tb_memory_arbiter_2port.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package memory_arbiter_pkg;

  localparam int unsigned TAG_DEPTH_DEF   = 16;
  localparam int unsigned TAG_DEPTH_N_DEF = 4;

  localparam int unsigned MASK_W = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WDATA_W = 32;
  localparam int unsigned RDATA_W = 64;

  typedef enum logic {
    REQ_IF   = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [MASK_W-1:0]  mask;
    logic               rw;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/memory_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; synchronous reset and flush.
module memory_arbiter_tag_fifo
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = TAG_DEPTH_DEF,
  parameter int unsigned DEPTH_N = TAG_DEPTH_N_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  req_id_t          push_id_i,
  input  logic             pop_i,
  output logic [DEPTH_N:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output req_id_t          head_o
);

  localparam int unsigned CW = DEPTH_N + 1;

  req_id_t              mem_q [DEPTH];
  logic [DEPTH_N-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_N-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally at DEPTH = 2**DEPTH_N
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_N'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_N'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/memory_arbiter_2port.sv
// Round-robin merge of fetch and data ports onto one memory request bus,
// with in-order tag tracking to steer read responses back to their requester.
module memory_arbiter_2port
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TAG_DEPTH   = TAG_DEPTH_DEF,
  parameter int unsigned TAG_DEPTH_N = TAG_DEPTH_N_DEF
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iRESET_SYNC,
  input  logic                iIF_REQ,
  output logic                oIF_BUSY,
  input  logic [ADDR_W-1:0]   iIF_ADDR,
  output logic                oIF_VALID,
  input  logic                iIF_BUSY,
  output logic [RDATA_W-1:0]  oIF_DATA,
  input  logic                iDATA_REQ,
  output logic                oDATA_BUSY,
  input  logic [MASK_W-1:0]   iDATA_MASK,
  input  logic                iDATA_RW,
  input  logic [ADDR_W-1:0]   iDATA_ADDR,
  input  logic [WDATA_W-1:0]  iDATA_DATA,
  output logic                oDATA_VALID,
  input  logic                iDATA_BUSY,
  output logic [RDATA_W-1:0]  oDATA_DATA,
  output logic                oMEM_REQ,
  input  logic                iMEM_BUSY,
  output logic [MASK_W-1:0]   oMEM_MASK,
  output logic                oMEM_RW,
  output logic [ADDR_W-1:0]   oMEM_ADDR,
  output logic [WDATA_W-1:0]  oMEM_DATA,
  input  logic                iMEM_VALID,
  output logic                oMEM_BUSY,
  input  logic [RDATA_W-1:0]  iMEM_DATA,
  output logic                oERR_ORPHAN
);

  localparam int unsigned CW = TAG_DEPTH_N + 1;

  logic        in_reset;
  mem_req_t    req_q, req_d;
  logic        req_vld_q, req_vld_d;
  req_id_t     last_grant_q, last_grant_d;
  logic        orphan_q, orphan_d;

  mem_req_t    if_req, data_req;
  logic        xfer, reg_free;
  logic        if_elig, data_elig;
  logic        grant_if, grant_data;
  logic        tag_push, tag_pop;
  req_id_t     tag_push_id, tag_head;
  logic        tag_full, tag_empty;
  logic [CW-1:0] tag_count;
  logic        mem_busy_c;

  assign in_reset = !inRESET || iRESET_SYNC;

  assign xfer     = req_vld_q && !iMEM_BUSY;
  assign reg_free = !req_vld_q || xfer;

  // Writes need no tag, so only reads are held off by a full tag FIFO
  assign if_elig   = !in_reset && iIF_REQ && reg_free && !tag_full;
  assign data_elig = !in_reset && iDATA_REQ && reg_free && (iDATA_RW || !tag_full);

  always_comb begin
    grant_if   = 1'b0;
    grant_data = 1'b0;
    if (if_elig && data_elig) begin
      if (last_grant_q == REQ_IF) grant_data = 1'b1;
      else                        grant_if   = 1'b1;
    end else begin
      grant_if   = if_elig;
      grant_data = data_elig;
    end
  end

  assign oIF_BUSY   = !grant_if;
  assign oDATA_BUSY = !grant_data;

  always_comb begin
    if_req      = '0;
    if_req.addr = iIF_ADDR;
    data_req.mask = iDATA_MASK;
    data_req.rw   = iDATA_RW;
    data_req.addr = iDATA_ADDR;
    data_req.data = iDATA_DATA;
  end

  assign tag_push    = grant_if || (grant_data && !iDATA_RW);
  assign tag_push_id = grant_data ? REQ_DATA : REQ_IF;

  always_comb begin
    req_d        = req_q;
    req_vld_d    = req_vld_q;
    last_grant_d = last_grant_q;
    orphan_d     = orphan_q;
    if (grant_data) begin
      req_d        = data_req;
      req_vld_d    = 1'b1;
      last_grant_d = REQ_DATA;
    end else if (grant_if) begin
      req_d        = if_req;
      req_vld_d    = 1'b1;
      last_grant_d = REQ_IF;
    end else if (xfer) begin
      req_vld_d    = 1'b0;
    end
    if (iMEM_VALID && tag_empty) orphan_d = 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    if (in_reset) begin
      req_q        <= '0;
      req_vld_q    <= 1'b0;
      last_grant_q <= REQ_IF;
      orphan_q     <= 1'b0;
    end else begin
      req_q        <= req_d;
      req_vld_q    <= req_vld_d;
      last_grant_q <= last_grant_d;
      orphan_q     <= orphan_d;
    end
  end

  assign oMEM_REQ    = req_vld_q;
  assign oMEM_MASK   = req_q.mask;
  assign oMEM_RW     = req_q.rw;
  assign oMEM_ADDR   = req_q.addr;
  assign oMEM_DATA   = req_q.data;
  assign oERR_ORPHAN = orphan_q;

  // Responses return in request order; the tag head names the owner
  assign mem_busy_c  = !tag_empty && ((tag_head == REQ_DATA) ? iDATA_BUSY : iIF_BUSY);
  assign oMEM_BUSY   = mem_busy_c;
  assign oIF_VALID   = iMEM_VALID && !tag_empty && (tag_head == REQ_IF);
  assign oDATA_VALID = iMEM_VALID && !tag_empty && (tag_head == REQ_DATA);
  assign oIF_DATA    = iMEM_DATA;
  assign oDATA_DATA  = iMEM_DATA;
  assign tag_pop     = iMEM_VALID && !mem_busy_c && !tag_empty;

  memory_arbiter_tag_fifo #(
    .DEPTH   (TAG_DEPTH),
    .DEPTH_N (TAG_DEPTH_N)
  ) u_tag_fifo (
    .clk_i     (iCLOCK),
    .rst_ni    (inRESET),
    .flush_i   (iRESET_SYNC),
    .push_i    (tag_push),
    .push_id_i (tag_push_id),
    .pop_i     (tag_pop),
    .count_o   (tag_count),
    .full_o    (tag_full),
    .empty_o   (tag_empty),
    .head_o    (tag_head)
  );

  a_tag_count_bound: assert property (@(posedge iCLOCK) disable iff (in_reset)
    tag_count <= CW'(TAG_DEPTH));

endmodule

// File: tb/tb_memory_arbiter_2port.sv
// Scoreboard bench for memory_arbiter_2port with a one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_memory_arbiter_2port;
  import memory_arbiter_pkg::*;

  logic        iCLOCK = 1'b0;
  logic        inRESET, iRESET_SYNC;
  logic        iIF_REQ, oIF_BUSY, oIF_VALID, iIF_BUSY;
  logic [31:0] iIF_ADDR;
  logic [63:0] oIF_DATA;
  logic        iDATA_REQ, oDATA_BUSY, iDATA_RW, oDATA_VALID, iDATA_BUSY;
  logic [3:0]  iDATA_MASK;
  logic [31:0] iDATA_ADDR, iDATA_DATA;
  logic [63:0] oDATA_DATA;
  logic        oMEM_REQ, iMEM_BUSY, oMEM_RW, iMEM_VALID, oMEM_BUSY, oERR_ORPHAN;
  logic [3:0]  oMEM_MASK;
  logic [31:0] oMEM_ADDR, oMEM_DATA;
  logic [63:0] iMEM_DATA;

  always #5 iCLOCK = ~iCLOCK;

  memory_arbiter_2port #(.TAG_DEPTH(16), .TAG_DEPTH_N(4)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iIF_REQ(iIF_REQ), .oIF_BUSY(oIF_BUSY), .iIF_ADDR(iIF_ADDR),
    .oIF_VALID(oIF_VALID), .iIF_BUSY(iIF_BUSY), .oIF_DATA(oIF_DATA),
    .iDATA_REQ(iDATA_REQ), .oDATA_BUSY(oDATA_BUSY), .iDATA_MASK(iDATA_MASK),
    .iDATA_RW(iDATA_RW), .iDATA_ADDR(iDATA_ADDR), .iDATA_DATA(iDATA_DATA),
    .oDATA_VALID(oDATA_VALID), .iDATA_BUSY(iDATA_BUSY), .oDATA_DATA(oDATA_DATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY), .oMEM_MASK(oMEM_MASK),
    .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(iMEM_VALID), .oMEM_BUSY(oMEM_BUSY), .iMEM_DATA(iMEM_DATA),
    .oERR_ORPHAN(oERR_ORPHAN)
  );

  typedef struct { logic [3:0] mask; logic rw; logic [31:0] addr; logic [31:0] data; req_id_t port; } exp_req_t;
  typedef struct { logic [63:0] data; int ready; } mem_ent_t;
  typedef struct { req_id_t port; logic [63:0] data; } exp_rsp_t;

  exp_req_t exp_req_q[$];
  mem_ent_t mem_q[$];
  exp_rsp_t exp_rsp_q[$];
  int       rsp_log[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic resp_en = 1'b1;
  logic orphan_inj = 1'b0;
  logic exp_orphan = 1'b0;

  logic        s_if_busy, s_data_busy, s_mem_req, s_mem_rw, s_if_valid, s_data_valid;
  logic        s_mem_busy, s_orphan;
  logic [3:0]  s_mem_mask;
  logic [31:0] s_mem_addr, s_mem_data;
  logic [63:0] s_if_data;
  int          s_grant;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory contents: 0x100 holds 64'hA, other words derive from the address
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 64'hA;
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  task automatic idle();
    iIF_REQ   = 1'b0;
    iDATA_REQ = 1'b0;
  endtask

  // One clock: drive memory response, sample mid-cycle, score, advance past the edge
  task automatic cycle();
    exp_req_t er;
    exp_rsp_t rs;
    logic     exp_busy, flush, if_acc, d_acc, exp_orphan_n;
    if (orphan_inj) begin
      iMEM_VALID = 1'b1; iMEM_DATA = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (resp_en && mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      iMEM_VALID = 1'b1; iMEM_DATA = mem_q[0].data;
    end else begin
      iMEM_VALID = 1'b0; iMEM_DATA = '0;
    end
    #4;
    s_if_busy = oIF_BUSY;   s_data_busy = oDATA_BUSY; s_mem_req = oMEM_REQ;
    s_mem_rw = oMEM_RW;     s_mem_mask = oMEM_MASK;   s_mem_addr = oMEM_ADDR;
    s_mem_data = oMEM_DATA; s_if_valid = oIF_VALID;   s_data_valid = oDATA_VALID;
    s_mem_busy = oMEM_BUSY; s_orphan = oERR_ORPHAN;   s_if_data = oIF_DATA;
    if_acc = iIF_REQ && !oIF_BUSY;
    d_acc  = iDATA_REQ && !oDATA_BUSY;
    s_grant = if_acc ? 1 : (d_acc ? 2 : 0);
    exp_orphan_n = exp_orphan;
    flush = !inRESET || iRESET_SYNC;
    check_eq("orphan_flag", 64'(oERR_ORPHAN), 64'(exp_orphan));
    if (flush) begin
      check_eq("flush_if_busy", 64'(oIF_BUSY), 64'd1);
      check_eq("flush_data_busy", 64'(oDATA_BUSY), 64'd1);
      exp_req_q.delete(); mem_q.delete(); exp_rsp_q.delete();
      exp_orphan_n = 1'b0;
    end else begin
      check_eq("one_grant", 64'(if_acc && d_acc), 64'd0);
      if (iMEM_VALID) begin
        if (exp_rsp_q.size() == 0) begin
          check_eq("orphan_if_valid", 64'(oIF_VALID), 64'd0);
          check_eq("orphan_data_valid", 64'(oDATA_VALID), 64'd0);
          check_eq("orphan_mem_busy", 64'(oMEM_BUSY), 64'd0);
          exp_orphan_n = 1'b1;
        end else begin
          rs = exp_rsp_q[0];
          check_eq("rsp_if_valid", 64'(oIF_VALID), 64'(rs.port == REQ_IF));
          check_eq("rsp_data_valid", 64'(oDATA_VALID), 64'(rs.port == REQ_DATA));
          exp_busy = (rs.port == REQ_DATA) ? iDATA_BUSY : iIF_BUSY;
          check_eq("rsp_mem_busy", 64'(oMEM_BUSY), 64'(exp_busy));
          if (!exp_busy) begin
            if (rs.port == REQ_IF) check_eq("rsp_if_data", oIF_DATA, rs.data);
            else                   check_eq("rsp_data_data", oDATA_DATA, rs.data);
            rsp_log.push_back(int'(rs.port));
            void'(exp_rsp_q.pop_front());
          end
        end
        if (!orphan_inj && !oMEM_BUSY && mem_q.size() > 0) void'(mem_q.pop_front());
      end
      if (oMEM_REQ && !iMEM_BUSY) begin
        check_eq("mem_req_pending", 64'(exp_req_q.size() > 0), 64'd1);
        if (exp_req_q.size() > 0) begin
          er = exp_req_q.pop_front();
          check_eq("mem_mask", 64'(oMEM_MASK), 64'(er.mask));
          check_eq("mem_rw", 64'(oMEM_RW), 64'(er.rw));
          check_eq("mem_addr", 64'(oMEM_ADDR), 64'(er.addr));
          if (er.rw) check_eq("mem_wdata", 64'(oMEM_DATA), 64'(er.data));
          else begin
            mem_q.push_back('{mem_word(oMEM_ADDR), cyc + 1});
            exp_rsp_q.push_back('{er.port, mem_word(er.addr)});
          end
        end
      end
      if (if_acc) exp_req_q.push_back('{4'h0, 1'b0, iIF_ADDR, 32'h0, REQ_IF});
      if (d_acc)  exp_req_q.push_back('{iDATA_MASK, iDATA_RW, iDATA_ADDR, iDATA_DATA, REQ_DATA});
    end
    @(posedge iCLOCK);
    #1;
    cyc++;
    exp_orphan = exp_orphan_n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    resp_en = 1'b1;
    while ((exp_req_q.size() > 0 || exp_rsp_q.size() > 0) && n < 60) begin
      cycle();
      n++;
    end
    check_eq("drain_done", 64'(exp_req_q.size() + exp_rsp_q.size()), 64'd0);
  endtask

  initial begin
    inRESET = 1'b0; iRESET_SYNC = 1'b0;
    iIF_REQ = 1'b0; iIF_ADDR = '0; iIF_BUSY = 1'b0;
    iDATA_REQ = 1'b0; iDATA_MASK = '0; iDATA_RW = 1'b0; iDATA_ADDR = '0; iDATA_DATA = '0;
    iDATA_BUSY = 1'b0; iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = '0;
    @(posedge iCLOCK);
    #1;

    // Reset: requests ignored, registered outputs zero
    iIF_REQ = 1'b1; iDATA_REQ = 1'b1;
    repeat (2) cycle();
    inRESET = 1'b1; idle();
    cycle();
    check_eq("rst_mem_req", 64'(s_mem_req), 64'd0);
    check_eq("rst_mem_mask", 64'(s_mem_mask), 64'd0);
    check_eq("rst_mem_rw", 64'(s_mem_rw), 64'd0);
    check_eq("rst_mem_addr", 64'(s_mem_addr), 64'd0);
    check_eq("rst_mem_data", 64'(s_mem_data), 64'd0);

    // Single fetch
    iIF_REQ = 1'b1; iIF_ADDR = 32'h100;
    cycle();
    check_eq("fetch_accept", 64'(s_if_busy), 64'd0);
    idle();
    cycle();
    check_eq("fetch_mem_req", 64'(s_mem_req), 64'd1);
    check_eq("fetch_mem_addr", 64'(s_mem_addr), 64'h100);
    cycle();
    check_eq("fetch_if_valid", 64'(s_if_valid), 64'd1);
    check_eq("fetch_data_valid", 64'(s_data_valid), 64'd0);
    check_eq("fetch_if_data", s_if_data, 64'hA);
    drain();

    // Contention: alternating grants starting with data
    for (int i = 0; i < 6; i++) begin
      iIF_REQ = 1'b1; iIF_ADDR = 32'h1000 + 32'(i);
      iDATA_REQ = 1'b1; iDATA_RW = 1'b0; iDATA_MASK = 4'h0; iDATA_ADDR = 32'h2000 + 32'(i);
      cycle();
      check_eq("rr_grant", 64'(s_grant), (i % 2 == 0) ? 64'd2 : 64'd1);
    end
    drain();

    // Mixed write / fetch read / data read
    rsp_log.delete();
    iDATA_REQ = 1'b1; iDATA_RW = 1'b1; iDATA_MASK = 4'b0101;
    iDATA_ADDR = 32'h3000; iDATA_DATA = 32'h1234_5678;
    cycle();
    check_eq("mixed_wr_accept", 64'(s_data_busy), 64'd0);
    idle(); iIF_REQ = 1'b1; iIF_ADDR = 32'h3100;
    cycle();
    check_eq("mixed_if_accept", 64'(s_if_busy), 64'd0);
    idle(); iDATA_REQ = 1'b1; iDATA_RW = 1'b0; iDATA_MASK = 4'h0; iDATA_ADDR = 32'h3200;
    cycle();
    check_eq("mixed_rd_accept", 64'(s_data_busy), 64'd0);
    drain();
    check_eq("mixed_rsp_count", 64'(rsp_log.size()), 64'd2);
    if (rsp_log.size() == 2) begin
      check_eq("mixed_first_if", 64'(rsp_log[0]), 64'd0);
      check_eq("mixed_second_data", 64'(rsp_log[1]), 64'd1);
    end

    // Backpressure from memory request side
    iDATA_REQ = 1'b1; iDATA_RW = 1'b1; iDATA_MASK = 4'b1000;
    iDATA_ADDR = 32'h4000; iDATA_DATA = 32'hCAFE_0001;
    cycle();
    check_eq("bp_accept", 64'(s_data_busy), 64'd0);
    iMEM_BUSY = 1'b1; iIF_REQ = 1'b1; iIF_ADDR = 32'h4100;
    iDATA_ADDR = 32'h4104; iDATA_DATA = 32'hCAFE_0002;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_if_busy", 64'(s_if_busy), 64'd1);
      check_eq("bp_data_busy", 64'(s_data_busy), 64'd1);
      check_eq("bp_hold_req", 64'(s_mem_req), 64'd1);
      check_eq("bp_hold_addr", 64'(s_mem_addr), 64'h4000);
      check_eq("bp_hold_data", 64'(s_mem_data), 64'hCAFE_0001);
      check_eq("bp_hold_mask", 64'(s_mem_mask), 64'h8);
    end
    iMEM_BUSY = 1'b0;
    drain();

    // Backpressure from data sink with a DATA head
    iDATA_BUSY = 1'b1;
    iDATA_REQ = 1'b1; iDATA_RW = 1'b0; iDATA_MASK = 4'h0; iDATA_ADDR = 32'h4200;
    cycle();
    idle();
    cycle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("dbusy_valid", 64'(s_data_valid), 64'd1);
      check_eq("dbusy_mem_busy", 64'(s_mem_busy), 64'd1);
    end
    iDATA_BUSY = 1'b0;
    drain();

    // Tag FIFO full: reads blocked, writes still accepted
    resp_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iIF_REQ = 1'b1; iIF_ADDR = 32'h7000 + 32'(i);
      cycle();
      check_eq("fill_accept", 64'(s_if_busy), 64'd0);
    end
    iIF_ADDR = 32'h7010;
    iDATA_REQ = 1'b1; iDATA_RW = 1'b0; iDATA_ADDR = 32'h7100;
    cycle();
    check_eq("full_if_busy", 64'(s_if_busy), 64'd1);
    check_eq("full_data_rd_busy", 64'(s_data_busy), 64'd1);
    iDATA_RW = 1'b1; iDATA_DATA = 32'h0BAD_CAFE; iDATA_MASK = 4'h0;
    cycle();
    check_eq("full_if_busy2", 64'(s_if_busy), 64'd1);
    check_eq("full_data_wr_ok", 64'(s_data_busy), 64'd0);
    iDATA_REQ = 1'b0; resp_en = 1'b1;
    cycle();
    check_eq("full_pop_valid", 64'(s_if_valid), 64'd1);
    check_eq("full_pop_still_busy", 64'(s_if_busy), 64'd1);
    resp_en = 1'b0;
    cycle();
    check_eq("full_reenabled", 64'(s_if_busy), 64'd0);
    drain();

    // Orphan response
    orphan_inj = 1'b1;
    cycle();
    check_eq("orphan_consumed", 64'(s_mem_busy), 64'd0);
    orphan_inj = 1'b0;
    repeat (2) begin
      cycle();
      check_eq("orphan_sticky", 64'(s_orphan), 64'd1);
    end

    // Flush with outstanding tags and a pending request
    resp_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iIF_REQ = 1'b1; iIF_ADDR = 32'h5000 + 32'(i);
      cycle();
    end
    iRESET_SYNC = 1'b1;
    cycle();
    check_eq("flush_pending_req", 64'(s_mem_req), 64'd1);
    iRESET_SYNC = 1'b0; idle();
    cycle();
    check_eq("flush_mem_req", 64'(s_mem_req), 64'd0);
    check_eq("flush_orphan_clr", 64'(s_orphan), 64'd0);
    orphan_inj = 1'b1;
    cycle();
    check_eq("flush_tags_empty", 64'(s_if_valid), 64'd0);
    check_eq("flush_no_busy", 64'(s_mem_busy), 64'd0);
    orphan_inj = 1'b0;
    resp_en = 1'b1;
    iIF_REQ = 1'b1; iIF_ADDR = 32'h6000;
    cycle();
    check_eq("post_flush_accept", 64'(s_if_busy), 64'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
